// File: rtl/exec_pkg.sv
// Shared execute-stage types for the multiply stall controller: FSM states,
// multiply opcodes and the registered product-select encoding.
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [5:0] MULT_OP  = 6'h0e;
  localparam logic [5:0] MULTU_OP = 6'h16;

  typedef enum logic [1:0] {
    KIND_NONE     = 2'b00,
    KIND_SIGNED   = 2'b01,
    KIND_UNSIGNED = 2'b10
  } mult_kind_e;

endpackage

// File: rtl/mult_decode.sv
// Combinational multiply-op decode: flags a valid MULT/MULTU and gives its product kind.
module mult_decode
  import exec_pkg::*;
(
  input  logic       instr_valid_i,
  input  logic [5:0] alu_ctr_i,
  output logic       is_mult_o,
  output mult_kind_e kind_o
);

  always_comb begin
    kind_o = KIND_NONE;
    if (instr_valid_i) begin
      if (alu_ctr_i == MULT_OP)       kind_o = KIND_SIGNED;
      else if (alu_ctr_i == MULTU_OP) kind_o = KIND_UNSIGNED;
    end
  end

  assign is_mult_o = (kind_o != KIND_NONE);

endmodule

// File: rtl/mult_stall_ctrl.sv
// Multiply stall controller: stalls fetch while a multiply runs, pulses the start and
// result write-back. Define MULT_TIMEOUT_EN to force completion after MULT_TIMEOUT WAIT cycles.
module mult_stall_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned MULT_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] ALU_ctr,
  input  logic       mult_done,
  output logic       doMult,
  output logic       pc_en,
  output logic       result_we,
  output logic [1:0] mult_kind,
  output logic       busy,
  output logic       timeout_err
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  mult_kind_e kind_q, kind_d;
  logic       is_mult;
  mult_kind_e dec_kind;
  logic       do_mult_c, pc_en_c, we_c;
  logic       tout_set;

  mult_decode u_dec (
    .instr_valid_i (instr_valid),
    .alu_ctr_i     (ALU_ctr),
    .is_mult_o     (is_mult),
    .kind_o        (dec_kind)
  );

`ifdef MULT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(MULT_TIMEOUT - 1);
  logic timeout_hit;
  assign timeout_hit = (cnt_q == TO_LAST);
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    tout_set  = 1'b0;
    do_mult_c = 1'b0;
    pc_en_c   = 1'b1;
    we_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mult) begin
          pc_en_c = 1'b0;
          kind_d  = dec_kind;
          state_d = ISSUE;
        end else begin
          we_c = instr_valid;
        end
      end
      ISSUE: begin
        do_mult_c = 1'b1;
        pc_en_c   = 1'b0;
        cnt_d     = 8'd0;
        state_d   = WAIT;
      end
      WAIT: begin
        pc_en_c = 1'b0;
        cnt_d   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
        // A real completion in the timeout cycle wins and leaves the flag alone.
        if (mult_done) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d  = DONE;
          tout_set = 1'b1;
        end
      end
      DONE: begin
        we_c    = 1'b1;
        kind_d  = KIND_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      kind_q  <= KIND_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

`ifdef MULT_TIMEOUT_EN
  logic tout_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        tout_q <= 1'b0;
    else if (tout_set) tout_q <= 1'b1;
  end
  assign timeout_err = tout_q;
`else
  logic unused_tout;
  assign unused_tout = tout_set;
  assign timeout_err = 1'b0;
`endif

  // While reset is held the decode path must not stall fetch or write back.
  assign doMult    = reset & do_mult_c;
  assign pc_en     = ~reset | pc_en_c;
  assign result_we = reset & we_c;
  assign busy      = (state_q != IDLE);
  assign mult_kind = kind_q;

endmodule

// File: doc/mult_stall_ctrl.md
MULT_STALL_CTRL -- requirements
Module: mult_stall_ctrl

Interface
REQ-001 Parameter: MULT_TIMEOUT, default 40, max WAIT cycles before forced completion (range 2..255).
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 Port: instr_valid  input  1  current instruction word valid this cycle.
REQ-005 Port: ALU_ctr  input  6  decoded ALU control of current instruction.
REQ-006 Port: mult_done  input  1  completion level from multiplier pair.
REQ-007 Port: doMult  output  1  one-cycle start pulse to multipliers.
REQ-008 Port: pc_en  output  1  PC/fetch advance enable; 0 = stall.
REQ-009 Port: result_we  output  1  register-file write enable for execute result.
REQ-010 Port: mult_kind  output  2  registered product select: 00 none, 01 signed, 10 unsigned.
REQ-011 Port: busy  output  1  high in any state except IDLE.
REQ-012 Port: timeout_err  output  1  sticky timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-014 Mult op SHALL be instr_valid=1 with ALU_ctr 6'h0e (signed) or 6'h16 (unsigned).
REQ-015 IDLE, non-mult: pc_en=1, result_we=instr_valid, doMult=0, state stays IDLE.
REQ-016 IDLE, mult op: pc_en=0, result_we=0, next state ISSUE, mult_kind registered (01/10) on same edge.
REQ-017 ISSUE: doMult=1 for exactly one cycle, pc_en=0, result_we=0, cycle counter cleared, next WAIT.
REQ-018 WAIT: doMult=0, pc_en=0, result_we=0, counter +1 per cycle; mult_done=1 -> DONE.
REQ-019 mult_done SHALL be ignored in IDLE and ISSUE (stale done never completes an op).
REQ-020 DONE: pc_en=1, result_we=1 for exactly one cycle, then IDLE; mult_kind held through DONE, cleared to 00 on entering IDLE.
REQ-021 Issue-to-writeback latency SHALL be 1 (ISSUE) + N (WAIT cycles up to and including mult_done) + 1 (DONE).
REQ-022 ALU_ctr/instr_valid changes during ISSUE/WAIT/DONE SHALL be ignored; no re-issue of same instruction after DONE.
REQ-023 Counter SHALL be 8 bits, saturating, never wraps.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, counter=0, mult_kind=00, timeout_err=0; doMult=0, result_we=0, busy=0, pc_en=1 while in reset.
REQ-025 Reset mid-operation (ISSUE/WAIT/DONE) SHALL abandon the op with no result_we pulse; a subsequent mult_done SHALL be ignored.
REQ-026 Reset deassertion SHALL take effect on the next rising clk edge; first valid instruction is decoded that cycle.

Configuration
REQ-027 Macro MULT_TIMEOUT_EN defined: in WAIT with counter == MULT_TIMEOUT-1 and mult_done=0 -> DONE, timeout_err set (sticky until reset).
REQ-028 Same cycle mult_done=1 and timeout reached: completion wins, timeout_err unchanged.
REQ-029 MULT_TIMEOUT_EN undefined: WAIT holds indefinitely until mult_done; timeout_err tied 0; counter still present for debug.

Structure
REQ-030 Shared package exec_pkg SHALL hold state enum, opcode constants MULT_OP=6'h0e, MULTU_OP=6'h16, and mult_kind encodings.
REQ-031 One sub-module, mult_decode (combinational ALU_ctr/instr_valid -> is_mult, kind), SHALL be instantiated; FSM and counter stay in top.

Verification
REQ-032 ALU_ctr=6'h20, instr_valid=1 for 3 cycles -> pc_en=1, result_we=1 each cycle, doMult never high, busy=0.
REQ-033 ALU_ctr=6'h0e; mult_done after 5 WAIT cycles -> doMult one cycle, pc_en=0 for 7 cycles, one result_we pulse, mult_kind=01 through DONE.
REQ-034 ALU_ctr=6'h16 with mult_done already 1 in IDLE/ISSUE -> done ignored, WAIT entered, completes on WAIT-cycle done; mult_kind=10.
REQ-035 MULT_TIMEOUT_EN, MULT_TIMEOUT=8, mult_done held 0 -> DONE after 8 WAIT cycles, timeout_err=1 and stays 1 across next mult op.
REQ-036 reset pulled 0 in 3rd WAIT cycle -> immediate IDLE, pc_en=1, no result_we; later mult_done=1 produces no pulse.
REQ-037 mult_done=1 on exact timeout cycle -> DONE, timeout_err stays 0.
